// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared types and helpers for the N-channel LED pattern sequencer.
//   led_mode_t     : runtime-selectable pattern (CHASE, BOUNCE, COUNT, BLINK)
//   BDIR_UP/DOWN   : travel direction of the BOUNCE one-hot
//   mode_seed_lsb  : bit 0 of the pattern a mode starts from (all other bits
//                    of the seed are zero, so one bit describes the seed for
//                    every LED count)
// Configuration macro used by the sequencer: LED_PWM_EN (brightness gate).
// -----------------------------------------------------------------------------
package led_seq_pkg;

    typedef enum logic [1:0] {
        CHASE  = 2'b00,
        BOUNCE = 2'b01,
        COUNT  = 2'b10,
        BLINK  = 2'b11
    } led_mode_t;

    localparam logic BDIR_UP   = 1'b0;
    localparam logic BDIR_DOWN = 1'b1;

    // One-hot modes start with LED0 lit; COUNT and BLINK start dark.
    function automatic logic mode_seed_lsb(input led_mode_t m);
        return (m == CHASE) || (m == BOUNCE);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Free-standing prescaler shared by the board timers. Counts 0..DIV-1 while
// en is high and flags the terminal count combinationally so the consumer can
// register its own reaction on the same edge that wraps the counter.
// Ports:
//   clk   in  1  system clock, rising edge
//   rst   in  1  asynchronous, active-high reset (count returns to 0)
//   en    in  1  1 = count, 0 = hold current count
//   clr   in  1  synchronous restart from 0; wins over en
//   tick  out 1  high in the cycle whose rising edge ends a DIV-cycle period
// -----------------------------------------------------------------------------
module led_tick_gen #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // A 1-bit counter is kept even for DIV=1 so the width never collapses.
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    if (DIV < 1) begin : g_div_chk
        $error("led_tick_gen: DIV must be at least 1");
    end

    logic [CNT_W-1:0] cnt;
    logic             at_last;

    assign at_last = (cnt == CNT_LAST);
    assign tick    = en && at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (at_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_seq_n.sv
// -----------------------------------------------------------------------------
// led_seq_n
// N-channel LED pattern sequencer for the board top. A prescaler divides clk
// down to STEP_HZ; on every step the current pattern advances according to
// the latched mode. LED outputs come straight from flops.
// Optional feature macro: LED_PWM_EN -- adds the duty input and a PWM_BITS
// brightness gate on the LED outputs (LEDs are then dark after reset).
// Ports:
//   clk        in   1         system clock, rising edge
//   rst        in   1         asynchronous, active-high reset
//   en         in   1         1 = run, 0 = freeze prescaler and pattern
//   mode       in   2         pattern select, taken only on mode_load
//   dir        in   1         CHASE direction: 0 toward MSB, 1 toward LSB
//   mode_load  in   1         one-cycle pulse: latch mode and reseed pattern
//   duty       in   PWM_BITS  brightness (only with LED_PWM_EN)
//   led        out  N_LED     LED drive, active-high
//   step       out  1         one-cycle pulse alongside each new pattern
//   wrap       out  1         one-cycle pulse when a pattern cycle completes
// -----------------------------------------------------------------------------
module led_seq_n
    import led_seq_pkg::*;
#(
    parameter int N_LED    = 4,
    parameter int CLK_HZ   = 500_000000,
    parameter int STEP_HZ  = 1,
    parameter int PWM_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               dir,
    input  logic               mode_load,
`ifdef LED_PWM_EN
    input  logic [PWM_BITS-1:0] duty,
`endif
    output logic [N_LED-1:0]   led,
    output logic               step,
    output logic               wrap
);

    localparam int DIV = CLK_HZ / STEP_HZ;

    localparam logic [N_LED-1:0] PAT_LSB = N_LED'(1);
    localparam logic [N_LED-1:0] PAT_MSB = PAT_LSB << (N_LED - 1);

    if (N_LED < 1) begin : g_nled_chk
        $error("led_seq_n: N_LED must be at least 1");
    end
    if (DIV < 1) begin : g_div_chk
        $error("led_seq_n: CLK_HZ/STEP_HZ must be at least 1");
    end
    if (PWM_BITS < 1) begin : g_pwm_chk
        $error("led_seq_n: PWM_BITS must be at least 1");
    end

    led_mode_t        mode_q;
    logic [N_LED-1:0] pat;
    logic [N_LED-1:0] pat_nxt;
    logic [N_LED-1:0] rot_up;
    logic [N_LED-1:0] rot_dn;
    logic             bdir;
    logic             bdir_nxt;
    logic             wrap_nxt;
    logic             step_q;
    logic             wrap_q;
    logic             tick;

    // Step-rate prescaler; a mode_load restarts the step period.
    led_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (mode_load),
        .tick (tick)
    );

    // Rotations built bitwise so that N_LED=1 degenerates to "hold".
    always_comb begin
        rot_up = '0;
        rot_dn = '0;
        for (int i = 0; i < N_LED; i++) begin
            rot_up[i] = pat[(i + N_LED - 1) % N_LED];
            rot_dn[i] = pat[(i + 1) % N_LED];
        end
    end

    // Next pattern, BOUNCE direction and wrap flag for the coming step.
    always_comb begin
        pat_nxt  = pat;
        bdir_nxt = bdir;
        wrap_nxt = 1'b0;
        case (mode_q)
            CHASE: begin
                if (dir) begin
                    pat_nxt  = rot_dn;
                    wrap_nxt = (rot_dn == PAT_MSB);
                end else begin
                    pat_nxt  = rot_up;
                    wrap_nxt = (rot_up == PAT_LSB);
                end
            end
            BOUNCE: begin
                if (N_LED == 1) begin
                    pat_nxt  = pat;
                    wrap_nxt = 1'b1;
                end else if (bdir == BDIR_UP) begin
                    pat_nxt = pat << 1;
                    // Turn around as soon as the top LED is reached.
                    if (pat_nxt[N_LED-1]) begin
                        bdir_nxt = BDIR_DOWN;
                    end
                end else begin
                    pat_nxt = pat >> 1;
                    if (pat_nxt[0]) begin
                        bdir_nxt = BDIR_UP;
                        wrap_nxt = 1'b1;
                    end
                end
            end
            COUNT: begin
                pat_nxt  = pat + PAT_LSB;
                wrap_nxt = (pat_nxt == '0);
            end
            BLINK: begin
                pat_nxt  = ~pat;
                wrap_nxt = (pat_nxt == '0);
            end
            default: begin
                pat_nxt  = pat;
                bdir_nxt = bdir;
                wrap_nxt = 1'b0;
            end
        endcase
    end

    // Pattern state. mode_load wins over a coincident terminal count, so a
    // reseed never produces a step in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= CHASE;
            pat    <= PAT_LSB;
            bdir   <= BDIR_UP;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (mode_load) begin
            mode_q <= led_mode_t'(mode);
            pat    <= N_LED'(mode_seed_lsb(led_mode_t'(mode)));
            bdir   <= BDIR_UP;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (tick) begin
            pat    <= pat_nxt;
            bdir   <= bdir_nxt;
            step_q <= 1'b1;
            wrap_q <= wrap_nxt;
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end
    end

    assign step = step_q;
    assign wrap = wrap_q;

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pc;
    logic [PWM_BITS-1:0] duty_q;
    logic [N_LED-1:0]    led_q;

    // Duty is only taken at the PWM period boundary so a brightness change
    // never produces a runt pulse. The gate is registered, so the LEDs trail
    // the pattern register by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= '0;
            duty_q <= '0;
            led_q  <= '0;
        end else begin
            pc <= pc + PWM_BITS'(1);
            if (pc == '1) begin
                duty_q <= duty;
            end
            led_q <= pat & {N_LED{(pc < duty_q)}};
        end
    end

    assign led = led_q;
`else
    assign led = pat;
`endif

endmodule

// File: tb/tb_led_seq_n.sv
// -----------------------------------------------------------------------------
// tb_led_seq_n
// Directed bench for led_seq_n with N_LED=4, CLK_HZ=8, STEP_HZ=1 (DIV=8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_seq_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       dir;
    logic       mode_load;
    logic [3:0] led;
    logic       step;
    logic       wrap;
`ifdef LED_PWM_EN
    logic [3:0] duty;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] bseq [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

    led_seq_n #(
        .N_LED    (4),
        .CLK_HZ   (8),
        .STEP_HZ  (1),
        .PWM_BITS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .dir       (dir),
        .mode_load (mode_load),
`ifdef LED_PWM_EN
        .duty      (duty),
`endif
        .led       (led),
        .step      (step),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [3:0] l, input logic s, input logic w);
        chk({tag, ".led"}, 32'(led), 32'(l));
        chk({tag, ".step"}, 32'(step), 32'(s));
        chk({tag, ".wrap"}, 32'(wrap), 32'(w));
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        mode      = 2'b00;
        dir       = 1'b0;
        mode_load = 1'b0;
`ifdef LED_PWM_EN
        duty      = 4'd4;
        cyc(2);
        chk("pwm_reset_led", 32'(led), 32'h0);
        rst = 1'b0;
        cyc(40);
        begin
            int hi = 0;
            for (int i = 0; i < 32; i++) begin
                cyc(1);
                if (led != 4'b0000) hi++;
            end
            chk("pwm_duty4_on_cycles", 32'(hi), 32'd8);
        end
        duty = 4'd0;
        cyc(40);
        begin
            int hi = 0;
            for (int i = 0; i < 32; i++) begin
                cyc(1);
                if (led != 4'b0000) hi++;
            end
            chk("pwm_duty0_on_cycles", 32'(hi), 32'd0);
        end
`else
        // Reset state
        cyc(2);
        chk3("reset", 4'b0001, 1'b0, 1'b0);

        // CHASE toward MSB
        rst = 1'b0;
        en  = 1'b1;
        cyc(7);
        chk3("chase_pre", 4'b0001, 1'b0, 1'b0);
        cyc(1);
        chk3("chase_s1", 4'b0010, 1'b1, 1'b0);
        cyc(1);
        chk3("chase_s1_after", 4'b0010, 1'b0, 1'b0);
        cyc(7);
        chk3("chase_s2", 4'b0100, 1'b1, 1'b0);
        cyc(8);
        chk3("chase_s3", 4'b1000, 1'b1, 1'b0);
        cyc(8);
        chk3("chase_s4", 4'b0001, 1'b1, 1'b1);

        // BOUNCE
        mode      = 2'b01;
        mode_load = 1'b1;
        cyc(1);
        mode_load = 1'b0;
        chk3("bounce_load", 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(8);
            chk3("bounce_step", bseq[i], 1'b1, (i == 5));
        end

        // COUNT with an en freeze in the middle
        mode      = 2'b10;
        mode_load = 1'b1;
        cyc(1);
        mode_load = 1'b0;
        chk3("count_load", 4'b0000, 1'b0, 1'b0);
        for (int v = 1; v <= 5; v++) begin
            cyc(8);
            chk3("count_step", 4'(v), 1'b1, 1'b0);
        end
        cyc(3);
        en = 1'b0;
        cyc(20);
        chk3("count_frozen", 4'd5, 1'b0, 1'b0);
        en = 1'b1;
        cyc(4);
        chk3("count_resume_pre", 4'd5, 1'b0, 1'b0);
        cyc(1);
        chk3("count_resume", 4'd6, 1'b1, 1'b0);
        for (int v = 7; v <= 16; v++) begin
            cyc(8);
            chk3("count_step", 4'(v), 1'b1, (v == 16));
        end

        // mode_load on the terminal-count cycle: reseed, no step
        cyc(7);
        mode      = 2'b11;
        mode_load = 1'b1;
        cyc(1);
        mode_load = 1'b0;
        chk3("load_at_tc", 4'b0000, 1'b0, 1'b0);
        cyc(7);
        chk3("blink_pre", 4'b0000, 1'b0, 1'b0);
        cyc(1);
        chk3("blink_s1", 4'b1111, 1'b1, 1'b0);
        cyc(8);
        chk3("blink_s2", 4'b0000, 1'b1, 1'b1);
        cyc(8);
        chk3("blink_s3", 4'b1111, 1'b1, 1'b0);

        // Async reset right before a terminal count
        cyc(7);
        rst = 1'b1;
        #1;
        chk3("async_rst", 4'b0001, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        cyc(1);
        chk3("post_rst_1", 4'b0001, 1'b0, 1'b0);
        cyc(6);
        chk3("post_rst_7", 4'b0001, 1'b0, 1'b0);
        cyc(1);
        chk3("post_rst_step", 4'b0010, 1'b1, 1'b0);

        // CHASE toward LSB, dir is live
        dir = 1'b1;
        cyc(8);
        chk3("chase_dn_s1", 4'b0001, 1'b1, 1'b0);
        cyc(8);
        chk3("chase_dn_s2", 4'b1000, 1'b1, 1'b1);

        // mode_load accepted while en=0
        en        = 1'b0;
        mode      = 2'b10;
        mode_load = 1'b1;
        cyc(1);
        mode_load = 1'b0;
        chk3("load_en0", 4'b0000, 1'b0, 1'b0);
        cyc(10);
        chk3("load_en0_hold", 4'b0000, 1'b0, 1'b0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
